aes_vector_checker: RTL and testbench
=====================================

# aes_vector_checker

Self-checking stimulus sequencer for the AES datapath. It streams a programmable set of plaintext blocks into the encrypt path and captures the ciphertext. It then compares each decrypted block against the block it issued, and reports pass/fail, an error count and the first failing index. It sits between the vector memory/host and `AES_top`, and replaces fixed hand-edited plaintext vectors with a parametrised, on-chip regression.

## Interface
- `DATA_W`, 128: block width in bits.
- `DEPTH`, 16: vector memory entries (power of 2); `AW = $clog2(DEPTH)`.
- `MAX_OUT`, 4: maximum blocks issued but not yet compared (1..DEPTH).
- `TIMEOUT`, 1024: idle cycles in RUN/DRAIN before abort.
- `MODE`, 0: 0 = plaintexts from memory; 1 = generated, `pt = seed + index` (mod 2^DATA_W).

- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  one-cycle pulse, honoured only in IDLE or DONE.
- `num_blocks`  in  AW+1  blocks per run, sampled on `start`.
- `seed`  in  DATA_W  MODE 1 base value, sampled on `start`.
- `load_en`  in  1  memory write strobe, honoured only in IDLE or DONE.
- `load_addr`  in  AW  memory write address.
- `load_data`  in  DATA_W  memory write data.
- `pt_valid`  out  1  plaintext offered to encrypt path.
- `pt_data`  out  DATA_W  plaintext block.
- `pt_ready`  in  1  encrypt path accepts when `pt_valid & pt_ready`.
- `ct_valid`  in  1  ciphertext strobe from core.
- `ct_data`  in  DATA_W  ciphertext.
- `dec_valid`  in  1  decrypted-block strobe, in issue order.
- `dec_data`  in  DATA_W  decrypted block.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  state is DONE.
- `pass`  out  1  valid when `done`; 1 if no error, no timeout and no overrun.
- `err_count`  out  AW+1  mismatching blocks, saturating.
- `first_err_idx`  out  AW  index of first mismatch.
- `timeout`  out  1  watchdog abort flag.
- `overrun`  out  1  `dec_valid` seen with zero outstanding.
- `ct_count`  out  AW+1  ciphertext strobes this run, saturating.
- `last_ct`  out  DATA_W  most recent `ct_data`.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + `start`: go to RUN. Clear counters, flags, `issue_idx` and `cmp_idx`, and latch `num_blocks` and `seed`.
- MODE 0: `num_blocks` above DEPTH clamps to DEPTH. `num_blocks = 0` goes straight to DONE with `pass = 1`.
- RUN: offer block `issue_idx` while `issue_idx < n` and `outstanding < MAX_OUT`.
  - On handshake: `issue_idx++` and `outstanding++`.
  - When `issue_idx = n`, go to DRAIN.
- On `dec_valid` with `outstanding > 0`: compare `dec_data` against the expected block at `cmp_idx`, then `cmp_idx++` and `outstanding--`.
  - Mismatch: `err_count++`. On the first mismatch, also capture `first_err_idx = cmp_idx`.
- Handshake and `dec_valid` in the same cycle: `outstanding` is unchanged.
- `dec_valid` with `outstanding = 0`: set sticky `overrun`; no compare.
- DRAIN to DONE when `cmp_idx = n` and the final compare has registered.
- Watchdog: reloads on every handshake or `dec_valid`. On reaching TIMEOUT in RUN/DRAIN, set `timeout` and go to DONE.
- `ct_valid`: `ct_count++` (saturating) and `last_ct <= ct_data`. This is not compared; it is visibility only.
- `start` or `load_en` during RUN/DRAIN is ignored.
- `rst` low mid-run aborts to IDLE. Memory contents are retained, not reset.

## Timing
- Reset values: `pt_valid`, `busy`, `done`, `pass`, `timeout` and `overrun` are 0. `err_count`, `ct_count`, `first_err_idx`, `pt_data` and `last_ct` are 0.
- Memory is read synchronously, so `pt_valid` first rises 2 cycles after the `start` edge.
- `pt_data` is held stable while `pt_valid & !pt_ready`. `pt_valid` never drops without a handshake, except on reset or timeout.
- Back-to-back issue is possible at one block per cycle while `pt_ready = 1` and credit is available.
- `err_count` and `first_err_idx` update 1 cycle after `dec_valid`.
- `done` rises 1 cycle after the last compare registers. `done` and `pass` hold until the next `start` or reset.

## Structure
- Package `aes_pkg`: the `state_t` enum, the `AES_BLOCK_W = 128` constant, and the default test key `128'h100F0E0D0C0B0A090807060504030201`.
- Sub-module `aes_vec_mem`: 1 write port and 1 synchronous read port, DEPTH×DATA_W. It is reused for the expected-value lookup through a second read port, or the issued block is held in a MAX_OUT-deep FIFO.

## Test plan
- Load 15 vectors `128'h100F0E0D...01` through `128'h00FFFEFD...F1` and run `num_blocks = 15` against the real `AES_top` with the default key -> `done`, `pass = 1`, `err_count = 0`, `ct_count = 15`.
- Same run with a bench model that flips bit 0 of decrypted block 3 -> `err_count = 1`, `first_err_idx = 3`, `pass = 0`.
- Hold `pt_ready = 0` for 5 cycles mid-run with `MAX_OUT = 2` -> `pt_data` stable, never more than 2 outstanding, and all blocks compared in order.
- MODE 1, `seed = 128'hFF..FF`, `num_blocks = 3` -> issued blocks are `FF..FF`, `00..00` and `00..01` (wrap-around), and `pass = 1`.
- Model drops the final `dec_valid` -> `timeout = 1` after TIMEOUT idle cycles, `done = 1`, `pass = 0`.
- Assert `rst = 0` mid-RUN, then restart -> all outputs reset; memory still holds the vectors and the rerun passes. `num_blocks = 0` -> `done` with `pass = 1` and no `pt_valid`.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES vector checker and its memory.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam logic [AES_BLOCK_W-1:0] AES_DEFAULT_KEY = 128'h100F0E0D0C0B0A090807060504030201;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_t;

endpackage

// File: rtl/aes_vec_mem.sv
// Plaintext vector store: one write port, one synchronous read port.
module aes_vec_mem
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W = AES_BLOCK_W,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents deliberately survive reset so a rerun needs no reload.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/aes_vector_checker.sv
// Streams plaintext blocks to the encrypt path and checks decrypted blocks
// against the issued ones, reporting pass/fail, error count and first failure.
module aes_vector_checker
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W  = AES_BLOCK_W,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned MODE    = 0,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW:0]       num_blocks,
  input  logic [DATA_W-1:0] seed,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              pt_valid,
  output logic [DATA_W-1:0] pt_data,
  input  logic              pt_ready,
  input  logic              ct_valid,
  input  logic [DATA_W-1:0] ct_data,
  input  logic              dec_valid,
  input  logic [DATA_W-1:0] dec_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AW:0]       err_count,
  output logic [AW-1:0]     first_err_idx,
  output logic              timeout,
  output logic              overrun,
  output logic [AW:0]       ct_count,
  output logic [DATA_W-1:0] last_ct
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_N = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAX_OS  = CW'(MAX_OUT);
  localparam logic [PW-1:0] PTR_TOP = PW'(MAX_OUT - 1);
  localparam logic [WW-1:0] WD_TOP  = WW'(TIMEOUT - 1);

  state_t state_q, state_d;
  logic [AW:0]       n_q, fetch_idx_q, s1_idx_q, issue_idx_q, cmp_idx_q, n_start;
  logic [DATA_W-1:0] seed_q, pt_data_q, mem_rdata, next_pt, last_ct_q;
  logic              s1_vld_q, pt_valid_q, timeout_q, overrun_q;
  logic [DATA_W-1:0] fifo_mem [MAX_OUT];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     os_q, os_d;
  logic [AW:0]       err_count_q, ct_count_q;
  logic [AW-1:0]     first_err_idx_q;
  logic [WW-1:0]     wd_q;
  logic              idle_like, run_st, hs, cmp_en, ovr, mismatch;
  logic              s2_load, rd_en, activity, wd_expire, start_ok;

  aes_vec_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (load_en & idle_like),
    .waddr(load_addr),
    .wdata(load_data),
    .re   (rd_en),
    .raddr(fetch_idx_q[AW-1:0]),
    .rdata(mem_rdata)
  );

  always_comb begin
    idle_like = (state_q == StIdle) || (state_q == StDone);
    run_st    = (state_q == StRun);
    busy      = run_st || (state_q == StDrain);
    start_ok  = start && idle_like;
    hs        = pt_valid_q && pt_ready;
    cmp_en    = busy && dec_valid && (os_q != '0);
    ovr       = busy && dec_valid && (os_q == '0);
    mismatch  = cmp_en && (dec_data != fifo_mem[rd_ptr_q]);
    activity  = hs || dec_valid;
    wd_expire = busy && !activity && (wd_q == WD_TOP);
    os_d = os_q;
    if (hs && !cmp_en) os_d = os_q + CW'(1);
    else if (!hs && cmp_en) os_d = os_q - CW'(1);
    // Stage 2 (pt register) only takes a block when credit remains after this cycle.
    s2_load = run_st && s1_vld_q && (!pt_valid_q || hs) && (os_d < MAX_OS) && !wd_expire;
    rd_en   = run_st && (fetch_idx_q < n_q) && (!s1_vld_q || s2_load);
    next_pt = (MODE != 0) ? seed_q + DATA_W'(s1_idx_q) : mem_rdata;
    n_start = num_blocks;
    if ((MODE == 0) && (num_blocks > DEPTH_N)) n_start = DEPTH_N;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start_ok) state_d = (n_start == '0) ? StDone : StRun;
      StRun:          if (wd_expire) state_d = StDone;
                      else if (issue_idx_q == n_q) state_d = StDrain;
      StDrain:        if (wd_expire || (cmp_idx_q == n_q)) state_d = StDone;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hs) fifo_mem[wr_ptr_q] <= pt_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      n_q <= '0;
      seed_q <= '0;
      fetch_idx_q <= '0;
      s1_idx_q <= '0;
      s1_vld_q <= 1'b0;
      issue_idx_q <= '0;
      cmp_idx_q <= '0;
      pt_valid_q <= 1'b0;
      pt_data_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      os_q <= '0;
      err_count_q <= '0;
      first_err_idx_q <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      ct_count_q <= '0;
      last_ct_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      if (ct_valid) last_ct_q <= ct_data;
      if (start_ok) begin
        n_q <= n_start;
        seed_q <= seed;
        fetch_idx_q <= '0;
        s1_vld_q <= 1'b0;
        issue_idx_q <= '0;
        cmp_idx_q <= '0;
        pt_valid_q <= 1'b0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        os_q <= '0;
        err_count_q <= '0;
        first_err_idx_q <= '0;
        timeout_q <= 1'b0;
        overrun_q <= 1'b0;
        ct_count_q <= '0;
        wd_q <= '0;
      end else begin
        if (ct_valid && (ct_count_q != '1)) ct_count_q <= ct_count_q + (AW + 1)'(1);
        if (rd_en) begin
          fetch_idx_q <= fetch_idx_q + (AW + 1)'(1);
          s1_idx_q <= fetch_idx_q;
          s1_vld_q <= 1'b1;
        end else if (s2_load) begin
          s1_vld_q <= 1'b0;
        end
        if (s2_load) begin
          pt_valid_q <= 1'b1;
          pt_data_q <= next_pt;
        end else if (hs) begin
          pt_valid_q <= 1'b0;
        end
        if (hs) begin
          issue_idx_q <= issue_idx_q + (AW + 1)'(1);
          wr_ptr_q <= (wr_ptr_q == PTR_TOP) ? '0 : wr_ptr_q + PW'(1);
        end
        if (cmp_en) begin
          cmp_idx_q <= cmp_idx_q + (AW + 1)'(1);
          rd_ptr_q <= (rd_ptr_q == PTR_TOP) ? '0 : rd_ptr_q + PW'(1);
          if (mismatch) begin
            if (err_count_q == '0) first_err_idx_q <= cmp_idx_q[AW-1:0];
            if (err_count_q != '1) err_count_q <= err_count_q + (AW + 1)'(1);
          end
        end
        if (ovr) overrun_q <= 1'b1;
        os_q <= os_d;
        if (busy) wd_q <= activity ? '0 : wd_q + WW'(1);
        if (wd_expire) begin
          timeout_q <= 1'b1;
          pt_valid_q <= 1'b0;
          s1_vld_q <= 1'b0;
        end
      end
    end
  end

  assign pt_valid      = pt_valid_q;
  assign pt_data       = pt_data_q;
  assign done          = (state_q == StDone);
  assign pass          = done && !timeout_q && !overrun_q && (err_count_q == '0);
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign timeout       = timeout_q;
  assign overrun       = overrun_q;
  assign ct_count      = ct_count_q;
  assign last_ct       = last_ct_q;

endmodule

// File: tb/tb_aes_vector_checker.sv
// Directed bench: a loopback model of the encrypt/decrypt path drives two checkers
// (memory-sourced and generated plaintexts) through the main scenarios.
module tb_aes_vector_checker;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst, start0, start1, load_en, pt_ready, ct_valid, dec_valid;
  logic [4:0] num_blocks;
  logic [3:0] load_addr;
  logic [127:0] seed, load_data, ct_data, dec_data;

  logic pt_valid0, busy0, done0, pass0, timeout0, overrun0;
  logic pt_valid1, busy1, done1, pass1, timeout1, overrun1;
  logic [127:0] pt_data0, last_ct0, pt_data1, last_ct1;
  logic [4:0] err_count0, ct_count0, err_count1, ct_count1;
  logic [3:0] first_err_idx0, first_err_idx1;

  always #5 clk = ~clk;

  aes_vector_checker #(
    .DATA_W(128), .DEPTH(16), .MAX_OUT(2), .TIMEOUT(64), .MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0), .num_blocks(num_blocks), .seed(seed),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .pt_valid(pt_valid0), .pt_data(pt_data0), .pt_ready(pt_ready),
    .ct_valid(ct_valid), .ct_data(ct_data), .dec_valid(dec_valid), .dec_data(dec_data),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
    .first_err_idx(first_err_idx0), .timeout(timeout0), .overrun(overrun0),
    .ct_count(ct_count0), .last_ct(last_ct0)
  );

  aes_vector_checker #(
    .DATA_W(128), .DEPTH(16), .MAX_OUT(4), .TIMEOUT(64), .MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .num_blocks(num_blocks), .seed(seed),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .pt_valid(pt_valid1), .pt_data(pt_data1), .pt_ready(pt_ready),
    .ct_valid(ct_valid), .ct_data(ct_data), .dec_valid(dec_valid), .dec_data(dec_data),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .first_err_idx(first_err_idx1), .timeout(timeout1), .overrun(overrun1),
    .ct_count(ct_count1), .last_ct(last_ct1)
  );

  logic sel;
  logic pv, bz, dn, ps, to, ov;
  logic [127:0] pd, lc;
  logic [4:0] ec, cc;
  logic [3:0] fei;
  assign pv  = sel ? pt_valid1 : pt_valid0;
  assign pd  = sel ? pt_data1 : pt_data0;
  assign bz  = sel ? busy1 : busy0;
  assign dn  = sel ? done1 : done0;
  assign ps  = sel ? pass1 : pass0;
  assign to  = sel ? timeout1 : timeout0;
  assign ov  = sel ? overrun1 : overrun0;
  assign ec  = sel ? err_count1 : err_count0;
  assign cc  = sel ? ct_count1 : ct_count0;
  assign fei = sel ? first_err_idx1 : first_err_idx0;
  assign lc  = sel ? last_ct1 : last_ct0;

  typedef struct {
    logic [127:0] d;
    int due;
    int idx;
  } ent_t;

  ent_t q[$];
  logic [127:0] exp_pt[$];
  logic [127:0] vec [15];
  logic [127:0] prev_pt;
  bit prev_stall, any_pv;
  int n_checks = 0, n_pass = 0;
  int cyc_n = 0, issued, returned, max_os;
  int lat = 3, corrupt_idx = -1, drop_idx = -1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic prep();
    issued = 0; returned = 0; max_os = 0; any_pv = 0; prev_stall = 0;
    q.delete();
  endtask

  // One clock: observe the current cycle at the falling edge, then drive the model outputs.
  task automatic tick();
    ent_t e;
    if (prev_stall) begin
      check("pt_hold_valid", pv, 1);
      check("pt_hold_data", pd, prev_pt);
    end
    if (pv) any_pv = 1;
    if (pv && pt_ready) begin
      if (issued < exp_pt.size()) check("issue_order", pd, exp_pt[issued]);
      else check("issue_extra", issued, exp_pt.size());
      q.push_back('{d: pd, due: cyc_n + lat, idx: issued});
      issued++;
    end
    if (dec_valid) returned++;
    if (issued - returned > max_os) max_os = issued - returned;
    prev_stall = pv && !pt_ready;
    prev_pt = pd;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
    dec_valid = 0;
    ct_valid = 0;
    if (q.size() > 0 && q[0].due <= cyc_n) begin
      e = q.pop_front();
      if (e.idx != drop_idx) begin
        dec_valid = 1;
        dec_data = (e.idx == corrupt_idx) ? e.d ^ 128'h1 : e.d;
        ct_valid = 1;
        ct_data = e.d ^ AES_DEFAULT_KEY;
      end
    end
  endtask

  task automatic run(input bit s, input logic [4:0] n, input bit do_stall, input int budget);
    int stall_left;
    bit stalled;
    sel = s;
    num_blocks = n;
    pt_ready = 1;
    prep();
    if (s) start1 = 1;
    else start0 = 1;
    tick();
    start0 = 0;
    start1 = 0;
    if (n != 0) begin
      tick();
      check("pv_lat1", pv, 0);
      tick();
      check("pv_lat2", pv, 1);
      check("busy", bz, 1);
    end
    stalled = 0;
    stall_left = 0;
    for (int it = 0; it < budget && !dn; it++) begin
      if (do_stall && !stalled && it >= 3 && pv) begin
        pt_ready = 0;
        stalled = 1;
        stall_left = 5;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) pt_ready = 1;
      end
      tick();
    end
    check("done_reached", dn, 1);
    pt_ready = 1;
  endtask

  task automatic reset_checks();
    check("rst_pt_valid", pv, 0);
    check("rst_busy", bz, 0);
    check("rst_done", dn, 0);
    check("rst_pass", ps, 0);
    check("rst_timeout", to, 0);
    check("rst_overrun", ov, 0);
    check("rst_err_count", ec, 0);
    check("rst_ct_count", cc, 0);
    check("rst_first_err", fei, 0);
    check("rst_pt_data", pd, 0);
    check("rst_last_ct", lc, 0);
  endtask

  initial begin
    rst = 0; start0 = 0; start1 = 0; load_en = 0; pt_ready = 1; sel = 0;
    ct_valid = 0; dec_valid = 0; num_blocks = 0; seed = '0;
    load_addr = '0; load_data = '0; ct_data = '0; dec_data = '0;
    for (int i = 0; i < 15; i++) begin
      vec[i] = 128'h100F0E0D0C0B0A090807060504030201
               - 128'(i) * 128'h01010101010101010101010101010101;
    end
    vec[14] = 128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1;
    repeat (2) @(negedge clk);
    reset_checks();
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      load_en = 1;
      load_addr = 4'(i);
      load_data = vec[i];
      @(negedge clk);
    end
    load_en = 0;
    exp_pt.delete();
    for (int i = 0; i < 15; i++) exp_pt.push_back(vec[i]);

    // Clean run of 15 blocks.
    run(0, 15, 0, 200);
    check("a_pass", ps, 1);
    check("a_err_count", ec, 0);
    check("a_ct_count", cc, 15);
    check("a_last_ct", lc, vec[14] ^ AES_DEFAULT_KEY);
    check("a_returned", returned, 15);
    check("a_credit", max_os <= 2, 1);

    // Bit 0 of decrypted block 3 flipped.
    corrupt_idx = 3;
    run(0, 15, 0, 200);
    corrupt_idx = -1;
    check("b_err_count", ec, 1);
    check("b_first_err", fei, 3);
    check("b_pass", ps, 0);

    // pt_ready held low 5 cycles while a block is offered.
    run(0, 15, 1, 200);
    check("c_pass", ps, 1);
    check("c_returned", returned, 15);
    check("c_credit", max_os <= 2, 1);
    check("c_credit_used", max_os, 2);

    // Generated plaintexts wrap modulo 2^128.
    seed = '1;
    exp_pt.delete();
    exp_pt.push_back(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    exp_pt.push_back(128'h0);
    exp_pt.push_back(128'h1);
    run(1, 3, 0, 100);
    check("d_pass", ps, 1);
    check("d_issued", issued, 3);
    sel = 0;
    exp_pt.delete();
    for (int i = 0; i < 15; i++) exp_pt.push_back(vec[i]);

    // Final decrypt strobe lost: watchdog must abort.
    drop_idx = 14;
    run(0, 15, 0, 300);
    drop_idx = -1;
    check("e_timeout", to, 1);
    check("e_done", dn, 1);
    check("e_pass", ps, 0);

    // Reset mid-run, then rerun from retained memory.
    sel = 0;
    num_blocks = 15;
    prep();
    start0 = 1;
    tick();
    start0 = 0;
    repeat (6) tick();
    check("f_busy_before_rst", bz, 1);
    rst = 0;
    #1;
    reset_checks();
    dec_valid = 0;
    ct_valid = 0;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    run(0, 15, 0, 200);
    check("f_pass", ps, 1);
    check("f_err_count", ec, 0);
    check("f_ct_count", cc, 15);

    run(0, 0, 0, 20);
    check("g_pass", ps, 1);
    check("g_no_pt_valid", any_pv, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
